// File: rtl/alu_pkg.sv
// Shared definitions for the slice-serial ALU: op encodings, flag positions,
// slice width and small op-classification helpers.
package alu_pkg;

    localparam int SLICE_W = 4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } alu_state_e;

    function automatic logic is_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
    endfunction

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_ADC) || is_sub(op);
    endfunction

    function automatic logic uses_cin(input logic [2:0] op);
        return (op == OP_ADC) || (op == OP_SBC);
    endfunction

    function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                              input logic h, input logic c);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_H] = h;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/alu_if.sv
// Request/completion bundle between the sequencer (master) and the ALU (slave).
interface alu_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_c;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    modport master (
        output start, op, in_a, in_b, in_c,
        input  busy, done, result, flags
    );

    modport slave (
        input  start, op, in_a, in_b, in_c,
        output busy, done, result, flags
    );
endinterface

// File: rtl/alu_slice.sv
// Combinational 4-bit ALU slice; cout is carry for add ops and borrow for
// subtract ops, zero for bitwise ops.
module alu_slice
    import alu_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    input  logic [2:0]         op,
    output logic [SLICE_W-1:0] y,
    output logic               cout
);

    logic [SLICE_W:0] sum;
    logic [SLICE_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
    assign diff = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, cin};

    always_comb begin
        y    = '0;
        cout = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                y    = sum[SLICE_W-1:0];
                cout = sum[SLICE_W];
            end
            OP_SUB, OP_SBC, OP_CP: begin
                y    = diff[SLICE_W-1:0];
                cout = diff[SLICE_W];
            end
            OP_AND:  y = a & b;
            OP_XOR:  y = a ^ b;
            OP_OR:   y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: one shared 4-bit slice walks the operands low slice first,
// chaining carry/borrow, and publishes result/flags only at completion.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = $clog2(NSLICE);

    alu_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic             half_q, half_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;

    logic [SLICE_W-1:0] slice_y;
    logic               slice_cout;
    logic [WIDTH-1:0]   final_val;
    logic [WIDTH-1:0]   a_rot;

    alu_slice u_slice (
        .a    (a_q[SLICE_W-1:0]),
        .b    (b_q[SLICE_W-1:0]),
        .cin  (carry_q),
        .op   (op_q),
        .y    (slice_y),
        .cout (slice_cout)
    );

    // Operands rotate rather than shift so that A is whole again on the last
    // slice, which CP needs as its result.
    assign final_val = {slice_y, part_q[WIDTH-1:SLICE_W]};
    assign a_rot     = {a_q[SLICE_W-1:0], a_q[WIDTH-1:SLICE_W]};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        half_d   = half_q;
        part_d   = part_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    op_d    = bus.op;
                    idx_d   = '0;
                    carry_d = uses_cin(bus.op) ? bus.in_c : 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_rot;
                b_d     = {b_q[SLICE_W-1:0], b_q[WIDTH-1:SLICE_W]};
                part_d  = final_val;
                carry_d = slice_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NSLICE - 2)) begin
                    half_d = slice_cout;
                end
                if (idx_q == IDX_W'(NSLICE - 1)) begin
                    idx_d    = '0;
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    result_d = (op_q == OP_CP) ? a_rot : final_val;
                    flags_d  = pack_flags(final_val == '0,
                                          is_sub(op_q),
                                          is_arith(op_q) ? half_q : (op_q == OP_AND),
                                          is_arith(op_q) ? slice_cout : 1'b0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            carry_q  <= 1'b0;
            half_q   <= 1'b0;
            part_q   <= '0;
            result_q <= '0;
            flags_q  <= 4'b0000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            half_q   <= half_d;
            part_q   <= part_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q == ST_RUN);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.flags  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16: expected results are
// queued by a full-width reference model when each op is issued.
module tb_alu_seq;

    localparam logic [2:0] T_ADD = 3'd0;
    localparam logic [2:0] T_ADC = 3'd1;
    localparam logic [2:0] T_SUB = 3'd2;
    localparam logic [2:0] T_SBC = 3'd3;
    localparam logic [2:0] T_AND = 3'd4;
    localparam logic [2:0] T_XOR = 3'd5;
    localparam logic [2:0] T_OR  = 3'd6;
    localparam logic [2:0] T_CP  = 3'd7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_if #(.WIDTH(8))  if8 ();
    alu_if #(.WIDTH(16)) if16 ();

    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    typedef struct {
        bit          w16;
        logic [15:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t model(input bit w16, input logic [2:0] op,
                                   input logic [15:0] a_in, input logic [15:0] b_in,
                                   input logic c);
        exp_t e;
        int w, mask, hm, a, b, ci, r, h, cy;
        bit sub;
        w    = w16 ? 16 : 8;
        mask = (1 << w) - 1;
        hm   = (1 << (w - 4)) - 1;
        a    = int'(a_in) & mask;
        b    = int'(b_in) & mask;
        ci   = ((op == T_ADC || op == T_SBC) && c) ? 1 : 0;
        sub  = (op == T_SUB || op == T_SBC || op == T_CP);
        h    = 0;
        cy   = 0;
        r    = 0;
        if (op == T_ADD || op == T_ADC) begin
            r  = a + b + ci;
            cy = (r > mask) ? 1 : 0;
            h  = (((a & hm) + (b & hm) + ci) > hm) ? 1 : 0;
            r  = r & mask;
        end else if (sub) begin
            r  = (a - b - ci) & mask;
            cy = (a < b + ci) ? 1 : 0;
            h  = ((a & hm) < ((b & hm) + ci)) ? 1 : 0;
        end else if (op == T_AND) begin
            r = a & b;
            h = 1;
        end else if (op == T_XOR) begin
            r = a ^ b;
        end else begin
            r = a | b;
        end
        e.w16 = w16;
        e.res = (op == T_CP) ? a[15:0] : r[15:0];
        e.flg = {(r == 0), sub, (h != 0), (cy != 0)};
        return e;
    endfunction

    function automatic logic get_done(input bit w16);
        return w16 ? if16.done : if8.done;
    endfunction

    function automatic logic get_busy(input bit w16);
        return w16 ? if16.busy : if8.busy;
    endfunction

    function automatic logic [15:0] get_result(input bit w16);
        return w16 ? if16.result : {8'h00, if8.result};
    endfunction

    function automatic logic [3:0] get_flags(input bit w16);
        return w16 ? if16.flags : if8.flags;
    endfunction

    // Called just after a negedge; holds start for exactly one rising edge.
    task automatic issue(input bit w16, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic c);
        if (w16) begin
            if16.start = 1'b1; if16.op = op; if16.in_a = a; if16.in_b = b; if16.in_c = c;
        end else begin
            if8.start = 1'b1; if8.op = op; if8.in_a = a[7:0]; if8.in_b = b[7:0]; if8.in_c = c;
        end
        exp_q.push_back(model(w16, op, a, b, c));
        @(negedge clk);
        if (w16) if16.start = 1'b0;
        else     if8.start = 1'b0;
    endtask

    task automatic wait_done(input bit w16, input string name, input int cyc0);
        int   cyc;
        exp_t e;
        cyc = cyc0;
        while (!get_done(w16) && cyc < 12) begin
            if (cyc >= 2) begin
                checks++;
                if (get_busy(w16) !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_run cyc=%0d got=%b want=1", name, cyc, get_busy(w16));
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (get_done(w16) !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout got=%b want=1", name, get_done(w16));
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        checks++;
        if (cyc != (w16 ? 5 : 3)) begin
            errors++;
            $display("FAIL %s latency got=%0d want=%0d", name, cyc, (w16 ? 5 : 3));
        end
        checks++;
        if (get_busy(w16) !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_in_done got=%b want=0", name, get_busy(w16));
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard_empty got=done want=no_done", name);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (get_result(w16) !== e.res) begin
            errors++;
            $display("FAIL %s result got=%h want=%h", name, get_result(w16), e.res);
        end
        checks++;
        if (get_flags(w16) !== e.flg) begin
            errors++;
            $display("FAIL %s flags got=%b want=%b", name, get_flags(w16), e.flg);
        end
    endtask

    task automatic pulse_end(input bit w16, input string name);
        @(negedge clk);
        checks++;
        if (get_done(w16) !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse_width got=%b want=0", name, get_done(w16));
        end
    endtask

    task automatic check_idle_zero(input bit w16, input string name);
        checks++;
        if ({get_busy(w16), get_done(w16), get_result(w16), get_flags(w16)} !== 22'd0) begin
            errors++;
            $display("FAIL %s outputs got busy=%b done=%b result=%h flags=%b want all 0",
                     name, get_busy(w16), get_done(w16), get_result(w16), get_flags(w16));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_zero(1'b0, "reset_w8");
        check_idle_zero(1'b1, "reset_w16");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero(1'b0, "post_reset_w8");
        check_idle_zero(1'b1, "post_reset_w16");
    endtask

    task automatic test_arith8();
        issue(1'b0, T_ADD, 16'h003A, 16'h00C6, 1'b0);
        wait_done(1'b0, "add8_zero", 1);
        pulse_end(1'b0, "add8_zero");
        issue(1'b0, T_SUB, 16'h003E, 16'h003F, 1'b0);
        wait_done(1'b0, "sub8_borrow", 1);
        pulse_end(1'b0, "sub8_borrow");
        issue(1'b0, T_SBC, 16'h003B, 16'h002A, 1'b1);
        wait_done(1'b0, "sbc8_cin", 1);
        pulse_end(1'b0, "sbc8_cin");
        issue(1'b0, T_ADC, 16'h000F, 16'h0000, 1'b1);
        wait_done(1'b0, "adc8_half", 1);
        pulse_end(1'b0, "adc8_half");
        issue(1'b0, T_ADD, 16'h00F0, 16'h0011, 1'b1);
        wait_done(1'b0, "add8_ignores_cin", 1);
        pulse_end(1'b0, "add8_ignores_cin");
    endtask

    task automatic test_back_to_back();
        issue(1'b0, T_CP, 16'h003C, 16'h003C, 1'b0);
        wait_done(1'b0, "cp8_equal", 1);
        issue(1'b0, T_AND, 16'h005A, 16'h003F, 1'b0);
        wait_done(1'b0, "and8_b2b", 1);
        issue(1'b0, T_XOR, 16'h00FF, 16'h00FF, 1'b0);
        wait_done(1'b0, "xor8_b2b", 1);
        issue(1'b0, T_OR, 16'h0080, 16'h0001, 1'b0);
        wait_done(1'b0, "or8_b2b", 1);
        pulse_end(1'b0, "or8_b2b");
    endtask

    task automatic test_w16_ignore_start();
        int extra;
        issue(1'b1, T_ADD, 16'h8A23, 16'h0605, 1'b0);
        @(negedge clk);
        if16.start = 1'b1; if16.op = T_SUB; if16.in_a = 16'hFFFF; if16.in_b = 16'h0001;
        @(negedge clk);
        if16.start = 1'b0;
        wait_done(1'b1, "add16_ignore_start", 3);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (if16.done === 1'b1) extra++;
        end
        checks++;
        if (extra != 0 || if16.busy !== 1'b0) begin
            errors++;
            $display("FAIL add16_spurious_op got done_count=%0d busy=%b want 0/0", extra, if16.busy);
        end
        issue(1'b1, T_CP, 16'h1000, 16'h1001, 1'b0);
        wait_done(1'b1, "cp16_borrow", 1);
        pulse_end(1'b1, "cp16_borrow");
    endtask

    task automatic test_reset_abort();
        int seen;
        issue(1'b0, T_ADD, 16'h003A, 16'h00C6, 1'b0);
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (if8.done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_done got=%0d want=0", seen);
        end
        check_idle_zero(1'b0, "abort_w8");
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, T_ADD, 16'h0001, 16'h0001, 1'b0);
        wait_done(1'b0, "add8_after_abort", 1);
        pulse_end(1'b0, "add8_after_abort");
    endtask

    task automatic test_random();
        bit          w16;
        logic [2:0]  op;
        logic [15:0] a, b;
        logic        c;
        for (int i = 0; i < 24; i++) begin
            w16 = bit'($urandom_range(0, 1));
            op  = 3'($urandom_range(0, 7));
            a   = 16'($urandom);
            b   = (i % 6 == 0) ? a : 16'($urandom);
            c   = 1'($urandom_range(0, 1));
            issue(w16, op, a, b, c);
            wait_done(w16, "random", 1);
        end
        pulse_end(1'b1, "random_tail");
    endtask

    initial begin
        rst_n = 1'b0;
        if8.start = 1'b0;  if8.op = 3'd0;  if8.in_a = '0;  if8.in_b = '0;  if8.in_c = 1'b0;
        if16.start = 1'b0; if16.op = 3'd0; if16.in_a = '0; if16.in_b = '0; if16.in_c = 1'b0;
        test_reset();
        test_arith8();
        test_back_to_back();
        test_w16_ignore_start();
        test_reset_abort();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
